// File: rtl/cap_rec_loader_pkg.sv
// Shared widths, record layout, permission bits and fault codes for the capability
// record load path (also used by the CST store side).
package cap_rec_loader_pkg;

  localparam int CAP_W         = 48;
  localparam int WORD_W        = 24;
  localparam int PERM_W        = 24;
  localparam int CAP_REC_WORDS = 10;
  localparam int REC_N         = CAP_REC_WORDS;
  localparam int CNT_W         = 4;

  // Word offsets inside the 10-word record
  localparam int CAP_W_BASE_LO = 0;
  localparam int CAP_W_BASE_HI = 1;
  localparam int CAP_W_LEN_LO  = 2;
  localparam int CAP_W_LEN_HI  = 3;
  localparam int CAP_W_CUR_LO  = 4;
  localparam int CAP_W_CUR_HI  = 5;
  localparam int CAP_W_PERMS   = 6;
  localparam int CAP_W_ATTR    = 7;
  localparam int CAP_W_TAG     = 8;
  localparam int CAP_W_RSV     = 9;

  localparam int CR_PERM_R_BIT  = 0;
  localparam int CR_PERM_LC_BIT = 2;

  typedef enum logic [1:0] {
    CAP_FLT_TAG    = 2'd0,
    CAP_FLT_PERM   = 2'd1,
    CAP_FLT_BOUNDS = 2'd2
  } cap_flt_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CHECK, ST_FETCH, ST_COMMIT, ST_FAULT
  } ld_state_e;

  // Only the R&LC verdict of the source perms matters after the start is accepted
  typedef struct packed {
    logic [CAP_W-1:0] ea;
    logic [CAP_W-1:0] base;
    logic [CAP_W-1:0] len;
    logic             perm_ok;
    logic             tag;
    logic [1:0]       dst;
  } ld_req_t;

  typedef struct packed {
    logic [CAP_W-1:0]  base;
    logic [CAP_W-1:0]  len;
    logic [CAP_W-1:0]  cur;
    logic [PERM_W-1:0] perms;
    logic [WORD_W-1:0] attr;
    logic              tag;
  } cap_rec_t;

  function automatic cap_rec_t rec_unpack(input logic [CAP_W_ATTR:0][WORD_W-1:0] s,
                                          input logic t);
    cap_rec_t r;
    r.base  = {s[CAP_W_BASE_HI], s[CAP_W_BASE_LO]};
    r.len   = {s[CAP_W_LEN_HI],  s[CAP_W_LEN_LO]};
    r.cur   = {s[CAP_W_CUR_HI],  s[CAP_W_CUR_LO]};
    r.perms = s[CAP_W_PERMS];
    r.attr  = s[CAP_W_ATTR];
    r.tag   = t;
    return r;
  endfunction

endpackage

// File: rtl/cap_rec_loader_if.sv
// D-mem read port used by the record loader: in-order reads, request/grant then rvalid.
interface cap_rec_loader_if;
  import cap_rec_loader_pkg::*;

  logic              ow_mem_req;
  logic [CAP_W-1:0]  ow_mem_addr;
  logic              iw_mem_gnt;
  logic              iw_mem_rvalid;
  logic [WORD_W-1:0] iw_mem_rdata;

  modport master (output ow_mem_req, ow_mem_addr,
                  input  iw_mem_gnt, iw_mem_rvalid, iw_mem_rdata);
  modport slave  (input  ow_mem_req, ow_mem_addr,
                  output iw_mem_gnt, iw_mem_rvalid, iw_mem_rdata);
endinterface

// File: rtl/cap_rec_loader_bounds_chk.sv
// Record window check: [ea, ea+n) must sit inside [base, base+len); compared one bit
// wider than CAP_W so that neither end can wrap.
module cap_bounds_chk
  import cap_rec_loader_pkg::*;
(
  input  logic [CAP_W-1:0] ea,
  input  logic [CAP_W-1:0] base,
  input  logic [CAP_W-1:0] len,
  input  logic [CNT_W-1:0] n,
  output logic             in_bounds
);
  logic [CAP_W:0] ea_end;
  logic [CAP_W:0] lim;

  assign ea_end    = {1'b0, ea} + (CAP_W+1)'(n);
  assign lim       = {1'b0, base} + {1'b0, len};
  assign in_bounds = (ea >= base) && (ea_end <= lim);
endmodule

// File: rtl/cap_rec_loader.sv
// Load-side sequencer for the 10-word capability record: checks the source window,
// streams the record out of D-mem and commits base/len/cur/perms/attr/tag in one cycle.
module cap_rec_loader
  import cap_rec_loader_pkg::*;
(
  input  logic               iw_clk,
  input  logic               iw_rst,
  input  logic               iw_start,
  input  logic [CAP_W-1:0]   iw_ea,
  input  logic [CAP_W-1:0]   iw_src_base,
  input  logic [CAP_W-1:0]   iw_src_len,
  input  logic [PERM_W-1:0]  iw_src_perms,
  input  logic               iw_src_tag,
  input  logic [1:0]         iw_dst,
  output logic               ow_busy,
  output logic               ow_done,
  output logic               ow_fault,
  output logic [1:0]         ow_fault_code,
  cap_rec_loader_if.master   mem,
  output logic               ow_cr_we,
  output logic [1:0]         ow_cr_idx,
  output logic [CAP_W-1:0]   ow_cr_base,
  output logic [CAP_W-1:0]   ow_cr_len,
  output logic [CAP_W-1:0]   ow_cr_cur,
  output logic [PERM_W-1:0]  ow_cr_perms,
  output logic [WORD_W-1:0]  ow_cr_attr,
  output logic               ow_cr_tag
);
  localparam logic [CNT_W-1:0] N_WORDS  = CNT_W'(REC_N);
  localparam logic [CNT_W-1:0] TAG_IDX  = CNT_W'(CAP_W_TAG);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CAP_W_RSV);

  ld_state_e state, state_nxt;
  ld_req_t   req_q;
  cap_rec_t  cr_q;
  cap_flt_e  flt_q, chk_flt;
  logic [CNT_W-1:0]                iss_cnt, rcv_cnt;
  logic [CAP_W_ATTR:0][WORD_W-1:0] slot_q;
  logic [1:0] idx_q;
  logic       tag_q, chk_ok, in_bounds, rcv_fire, rcv_last;

  cap_bounds_chk u_bounds (
    .ea        (req_q.ea),
    .base      (req_q.base),
    .len       (req_q.len),
    .n         (N_WORDS),
    .in_bounds (in_bounds)
  );

  assign rcv_fire = (state == ST_FETCH) && mem.iw_mem_rvalid && (rcv_cnt != N_WORDS);
  assign rcv_last = rcv_fire && (rcv_cnt == LAST_IDX);

  always_comb begin
    chk_ok  = 1'b0;
    chk_flt = CAP_FLT_BOUNDS;
    if (!req_q.tag)          chk_flt = CAP_FLT_TAG;
    else if (!req_q.perm_ok) chk_flt = CAP_FLT_PERM;
    else if (!in_bounds)     chk_flt = CAP_FLT_BOUNDS;
    else                     chk_ok  = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (iw_start) state_nxt = ST_CHECK;
      ST_CHECK:  state_nxt = chk_ok ? ST_FETCH : ST_FAULT;
      ST_FETCH:  if (rcv_last) state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      ST_FAULT:  state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ow_busy         = (state != ST_IDLE);
    ow_done         = (state == ST_COMMIT);
    ow_cr_we        = (state == ST_COMMIT);
    ow_fault        = (state == ST_FAULT);
    ow_fault_code   = flt_q;
    mem.ow_mem_req  = (state == ST_FETCH) && (iss_cnt != N_WORDS);
    mem.ow_mem_addr = mem.ow_mem_req ? req_q.ea + CAP_W'(iss_cnt) : '0;
  end

  assign ow_cr_idx   = idx_q;
  assign ow_cr_base  = cr_q.base;
  assign ow_cr_len   = cr_q.len;
  assign ow_cr_cur   = cr_q.cur;
  assign ow_cr_perms = cr_q.perms;
  assign ow_cr_attr  = cr_q.attr;
  assign ow_cr_tag   = cr_q.tag;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state   <= ST_IDLE;
      req_q   <= '0;
      iss_cnt <= '0;
      rcv_cnt <= '0;
      slot_q  <= '0;
      tag_q   <= 1'b0;
      cr_q    <= '0;
      idx_q   <= '0;
      flt_q   <= CAP_FLT_TAG;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && iw_start) begin
        req_q.ea      <= iw_ea;
        req_q.base    <= iw_src_base;
        req_q.len     <= iw_src_len;
        req_q.perm_ok <= iw_src_perms[CR_PERM_R_BIT] & iw_src_perms[CR_PERM_LC_BIT];
        req_q.tag     <= iw_src_tag;
        req_q.dst     <= iw_dst;
        iss_cnt       <= '0;
        rcv_cnt       <= '0;
      end
      if (state == ST_CHECK) flt_q <= chk_flt;
      if (mem.ow_mem_req && mem.iw_mem_gnt) iss_cnt <= iss_cnt + 1'b1;
      if (rcv_fire) begin
        rcv_cnt <= rcv_cnt + 1'b1;
        if (rcv_cnt < TAG_IDX)  slot_q[rcv_cnt[2:0]] <= mem.iw_mem_rdata;
        if (rcv_cnt == TAG_IDX) tag_q <= mem.iw_mem_rdata[0];
      end
      // The reserved word is always last, so every useful word is already in a slot here
      if (rcv_last) begin
        cr_q  <= rec_unpack(slot_q, tag_q);
        idx_q <= req_q.dst;
      end
    end
  end
endmodule

// File: tb/tb_cap_rec_loader.sv
// Randomized bench for cap_rec_loader: in-order D-mem responder with variable grant and
// read latency, output monitor, and a reference built from the record rules.
module tb_cap_rec_loader;
  import cap_rec_loader_pkg::*;

  logic        iw_clk, iw_rst, iw_start, iw_src_tag;
  logic [47:0] iw_ea, iw_src_base, iw_src_len;
  logic [23:0] iw_src_perms;
  logic [1:0]  iw_dst;
  logic        ow_busy, ow_done, ow_fault, ow_cr_we, ow_cr_tag;
  logic [1:0]  ow_fault_code, ow_cr_idx;
  logic [47:0] ow_cr_base, ow_cr_len, ow_cr_cur;
  logic [23:0] ow_cr_perms, ow_cr_attr;

  cap_rec_loader_if mem_if();

  cap_rec_loader dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_start(iw_start), .iw_ea(iw_ea),
    .iw_src_base(iw_src_base), .iw_src_len(iw_src_len), .iw_src_perms(iw_src_perms),
    .iw_src_tag(iw_src_tag), .iw_dst(iw_dst), .ow_busy(ow_busy), .ow_done(ow_done),
    .ow_fault(ow_fault), .ow_fault_code(ow_fault_code), .mem(mem_if),
    .ow_cr_we(ow_cr_we), .ow_cr_idx(ow_cr_idx), .ow_cr_base(ow_cr_base),
    .ow_cr_len(ow_cr_len), .ow_cr_cur(ow_cr_cur), .ow_cr_perms(ow_cr_perms),
    .ow_cr_attr(ow_cr_attr), .ow_cr_tag(ow_cr_tag)
  );

  localparam logic [23:0] P_RLC    = 24'h000005; // R (bit 0) | LC (bit 2)
  localparam logic [23:0] P_W_ONLY = 24'h000002;

  int total = 0, bad = 0, cyc = 0;

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;
  always @(posedge iw_clk) cyc <= cyc + 1;

  // ---------------- memory responder ----------------
  logic [23:0] mem [logic [47:0]];
  typedef struct { logic [23:0] d; int due; } rsp_t;
  rsp_t        pend[$];
  logic [47:0] iss_q[$];
  int gnt_pct = 100, dmin = 1, dmax = 1, last_due = 0, rv_cnt = 0;

  function automatic logic [23:0] mem_rd(input logic [47:0] a);
    if (mem.exists(a)) return mem[a];
    return a[23:0] ^ 24'h5A5A5A;
  endfunction

  always @(negedge iw_clk) begin
    int due;
    mem_if.iw_mem_rvalid = 1'b0;
    mem_if.iw_mem_rdata  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_if.iw_mem_rvalid = 1'b1;
      mem_if.iw_mem_rdata  = pend[0].d;
      void'(pend.pop_front());
      rv_cnt++;
    end
    mem_if.iw_mem_gnt = ($urandom_range(0, 99) < gnt_pct);
    if (mem_if.iw_mem_gnt && mem_if.ow_mem_req) begin
      iss_q.push_back(mem_if.ow_mem_addr);
      due = cyc + $urandom_range(dmin, dmax);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{mem_rd(mem_if.ow_mem_addr), due});
    end
  end

  // ---------------- output monitor ----------------
  int done_cnt, fault_cnt, we_cnt, busy_cnt, req_cnt, pulse_err, fault_cyc;
  int done_cyc_q[$];
  logic [1:0]   got_code, got_idx;
  logic [192:0] got_rec;

  always @(negedge iw_clk) begin
    if (ow_done) begin done_cnt++; done_cyc_q.push_back(cyc); end
    if (ow_cr_we) begin
      we_cnt++;
      got_idx = ow_cr_idx;
      got_rec = {ow_cr_base, ow_cr_len, ow_cr_cur, ow_cr_perms, ow_cr_attr, ow_cr_tag};
    end
    if (ow_done !== ow_cr_we) pulse_err++;
    if (ow_fault) begin fault_cnt++; fault_cyc = cyc; got_code = ow_fault_code; end
    if (ow_busy) busy_cnt++;
    if (mem_if.ow_mem_req) req_cnt++;
  end

  task automatic clr_mon();
    done_cnt = 0; fault_cnt = 0; we_cnt = 0; busy_cnt = 0; req_cnt = 0;
    pulse_err = 0; rv_cnt = 0; fault_cyc = -1; got_code = 'x; got_rec = 'x;
    done_cyc_q.delete(); iss_q.delete();
  endtask

  // ---------------- reference ----------------
  function automatic int model_flt(input longint unsigned ea, base, len,
                                   input logic [23:0] p, input logic t);
    if (!t) return 0;
    if (!(p[CR_PERM_R_BIT] && p[CR_PERM_LC_BIT])) return 1;
    if (ea < base || ea + 10 > base + len) return 2;
    return -1;
  endfunction

  function automatic logic [192:0] exp_rec(input logic [47:0] ea);
    logic [23:0] w [10];
    for (int k = 0; k < 10; k++) w[k] = mem_rd(ea + 48'(k));
    return {w[1], w[0], w[3], w[2], w[5], w[4], w[6], w[7], w[8][0]};
  endfunction

  task automatic load_rec300();
    logic [23:0] v [10];
    v = '{24'h1234, 24'h5678, 24'h50, 24'h0, 24'h1240, 24'h5678, 24'hF0, 24'h0F, 24'h1, 24'h0};
    for (int k = 0; k < 10; k++) mem[48'(300 + k)] = v[k];
  endtask

  // Single start pulse, then scrambles the inputs and waits for done or fault.
  task automatic run_load(input logic [47:0] ea, base, len, input logic [23:0] p,
                          input logic t, input logic [1:0] dst, output int n, output bit to);
    @(posedge iw_clk);
    clr_mon();
    @(negedge iw_clk);
    iw_ea = ea; iw_src_base = base; iw_src_len = len; iw_src_perms = p;
    iw_src_tag = t; iw_dst = dst; iw_start = 1'b1; n = cyc;
    @(negedge iw_clk);
    iw_start = 1'b0; iw_ea = {16'($urandom), 32'($urandom)}; iw_src_base = '0;
    iw_src_len = '0; iw_src_perms = 24'($urandom); iw_src_tag = ~t; iw_dst = ~dst;
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      @(posedge iw_clk);
      if (done_cnt + fault_cnt > 0) begin to = 1'b0; break; end
    end
    repeat (4) @(posedge iw_clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    iw_rst = 1'b1; iw_start = 1'b0; iw_ea = '0; iw_src_base = '0; iw_src_len = '0;
    iw_src_perms = '0; iw_src_tag = 1'b0; iw_dst = '0;
    repeat (3) @(posedge iw_clk);
    @(negedge iw_clk); iw_rst = 1'b0;
    @(negedge iw_clk);
    total++;
    if ({ow_busy, ow_done, ow_fault, ow_cr_we, mem_if.ow_mem_req} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000",
                      {ow_busy, ow_done, ow_fault, ow_cr_we, mem_if.ow_mem_req});
    end
    total++;
    if ({ow_cr_base, ow_cr_len, ow_cr_cur, ow_cr_perms, ow_cr_attr, ow_cr_tag, ow_cr_idx} !== '0) begin
      bad++; $display("FAIL reset_cr: got %h want 0", {ow_cr_base, ow_cr_len, ow_cr_cur});
    end
    total++;
    if ({ow_fault_code, mem_if.ow_mem_addr} !== '0) begin
      bad++; $display("FAIL reset_addr: got %h want 0", {ow_fault_code, mem_if.ow_mem_addr});
    end
  endtask

  task automatic test_basic();
    int n; bit to;
    gnt_pct = 100; dmin = 1; dmax = 1;
    load_rec300();
    run_load(48'd300, 48'd300, 48'd64, P_RLC, 1'b1, 2'd1, n, to);
    total++; if (to) begin bad++; $display("FAIL basic_timeout: got timeout want done"); end
    total++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != n + 13) begin
      bad++; $display("FAIL basic_latency: got %0d dones first at %0d want 1 at %0d",
                      done_cyc_q.size(), done_cyc_q.size() ? done_cyc_q[0] - n : -1, 13);
    end
    total++;
    if (got_rec !== {24'h5678, 24'h1234, 24'h0, 24'h50, 24'h5678, 24'h1240, 24'hF0, 24'h0F, 1'b1}) begin
      bad++; $display("FAIL basic_rec: got %h", got_rec);
    end
    total++;
    if ({we_cnt, fault_cnt, pulse_err, busy_cnt} != {32'd1, 32'd0, 32'd0, 32'd13} || got_idx !== 2'd1) begin
      bad++; $display("FAIL basic_ctl: got we=%0d flt=%0d perr=%0d busy=%0d idx=%0d want 1 0 0 13 1",
                      we_cnt, fault_cnt, pulse_err, busy_cnt, got_idx);
    end
    total++;
    if (ow_cr_base !== 48'h005678_001234 || ow_cr_cur !== 48'h005678_001240) begin
      bad++; $display("FAIL basic_hold: got base=%h cur=%h", ow_cr_base, ow_cr_cur);
    end
  endtask

  task automatic test_faults();
    int n; bit to;
    logic [23:0] ps [3];
    logic        ts [3];
    int          ec [3];
    ps = '{P_RLC, P_W_ONLY, 24'h000001}; ts = '{1'b0, 1'b1, 1'b1}; ec = '{0, 1, 1};
    for (int k = 0; k < 3; k++) begin
      run_load(48'd300, 48'd300, 48'd64, ps[k], ts[k], 2'd2, n, to);
      total++;
      if (to || fault_cyc != n + 2 || got_code !== 2'(ec[k]) || we_cnt != 0 || req_cnt != 0 || busy_cnt != 2) begin
        bad++; $display("FAIL fault_%0d: got to=%0d at=%0d code=%0d we=%0d req=%0d busy=%0d want 0 2 %0d 0 0 2",
                        k, to, fault_cyc - n, got_code, we_cnt, req_cnt, busy_cnt, ec[k]);
      end
    end
  endtask

  task automatic test_bounds();
    int n; bit to;
    logic [47:0] eas [5], bs [5], ls [5];
    int          ef;
    eas = '{48'd355, 48'd354, 48'd299, 48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFF0};
    bs  = '{48'd300, 48'd300, 48'd300, 48'hFFFF_FFFF_FFF8, 48'hFFFF_FFFF_FFF0};
    ls  = '{48'd64,  48'd64,  48'd64,  48'd8,              48'd16};
    for (int k = 0; k < 5; k++) begin
      ef = model_flt(eas[k], bs[k], ls[k], P_RLC, 1'b1);
      run_load(eas[k], bs[k], ls[k], P_RLC, 1'b1, 2'(k), n, to);
      total++;
      if (ef >= 0) begin
        if (to || fault_cnt != 1 || got_code !== 2'(ef) || we_cnt != 0) begin
          bad++; $display("FAIL bounds_%0d: got flt=%0d code=%0d we=%0d want 1 %0d 0",
                          k, fault_cnt, got_code, we_cnt, ef);
        end
      end else if (to || we_cnt != 1 || fault_cnt != 0 || got_rec !== exp_rec(eas[k])) begin
        bad++; $display("FAIL bounds_%0d: got we=%0d flt=%0d rec=%h want 1 0 %h",
                        k, we_cnt, fault_cnt, got_rec, exp_rec(eas[k]));
      end
    end
  endtask

  task automatic test_random_timing();
    int n; bit to; bit ord;
    gnt_pct = 50; dmin = 1; dmax = 4;
    load_rec300();
    run_load(48'd300, 48'd300, 48'd64, P_RLC, 1'b1, 2'd3, n, to);
    ord = (iss_q.size() == 10);
    for (int k = 0; k < iss_q.size(); k++) if (iss_q[k] !== 48'(300 + k)) ord = 1'b0;
    total++; if (!ord) begin bad++; $display("FAIL timing_order: got %0d reqs, first %h", iss_q.size(), iss_q.size() ? iss_q[0] : 48'h0); end
    total++;
    if (to || we_cnt != 1 || got_rec !== exp_rec(48'd300) || got_idx !== 2'd3) begin
      bad++; $display("FAIL timing_rec: got we=%0d rec=%h want 1 %h", we_cnt, got_rec, exp_rec(48'd300));
    end
    mem[48'd308] = 24'hFFFFFE;
    run_load(48'd300, 48'd300, 48'd64, P_RLC, 1'b1, 2'd0, n, to);
    total++;
    if (to || we_cnt != 1 || ow_cr_tag !== 1'b0 || got_rec !== exp_rec(48'd300)) begin
      bad++; $display("FAIL timing_tag0: got tag=%0d rec=%h want 0 %h", ow_cr_tag, got_rec, exp_rec(48'd300));
    end
    mem[48'd308] = 24'h1;
  endtask

  task automatic test_random();
    int n, ef; bit to;
    logic [47:0] b, l, e; logic [23:0] p; logic t;
    longint off;
    for (int it = 0; it < 14; it++) begin
      gnt_pct = $urandom_range(40, 100); dmin = 1; dmax = $urandom_range(1, 4);
      b = {16'($urandom), 32'($urandom)}; l = 48'($urandom_range(0, 80));
      off = longint'($urandom_range(0, 88)) - 5;
      e = b + 48'(off);
      p = 24'($urandom); if ($urandom_range(0, 3) != 0) p = p | P_RLC;
      t = ($urandom_range(0, 4) != 0);
      ef = model_flt(e, b, l, p, t);
      run_load(e, b, l, p, t, 2'($urandom), n, to);
      total++;
      if (ef >= 0) begin
        if (to || fault_cnt != 1 || got_code !== 2'(ef) || we_cnt != 0 || req_cnt != 0) begin
          bad++; $display("FAIL rand_%0d: got flt=%0d code=%0d we=%0d req=%0d want 1 %0d 0 0",
                          it, fault_cnt, got_code, we_cnt, req_cnt, ef);
        end
      end else if (to || we_cnt != 1 || fault_cnt != 0 || got_rec !== exp_rec(e)) begin
        bad++; $display("FAIL rand_%0d: got we=%0d flt=%0d rec=%h want 1 0 %h",
                        it, we_cnt, fault_cnt, got_rec, exp_rec(e));
      end
    end
  endtask

  task automatic test_reset_mid();
    int n; bit to;
    gnt_pct = 100; dmin = 2; dmax = 4;
    load_rec300();
    @(posedge iw_clk); clr_mon();
    @(negedge iw_clk);
    iw_ea = 48'd300; iw_src_base = 48'd300; iw_src_len = 48'd64; iw_src_perms = P_RLC;
    iw_src_tag = 1'b1; iw_dst = 2'd2; iw_start = 1'b1;
    @(negedge iw_clk); iw_start = 1'b0;
    for (int k = 0; k < 100 && rv_cnt < 4; k++) @(posedge iw_clk);
    @(negedge iw_clk); iw_rst = 1'b1;
    @(negedge iw_clk); iw_rst = 1'b0;
    for (int k = 0; k < 100 && pend.size() > 0; k++) @(posedge iw_clk);
    repeat (3) @(negedge iw_clk);
    total++;
    if (we_cnt != 0 || done_cnt != 0 || ow_busy !== 1'b0 || ow_cr_base !== 48'h0 || pend.size() != 0) begin
      bad++; $display("FAIL rstmid_abort: got we=%0d done=%0d busy=%0d base=%h pend=%0d want 0 0 0 0 0",
                      we_cnt, done_cnt, ow_busy, ow_cr_base, pend.size());
    end
    dmin = 1; dmax = 3;
    run_load(48'd300, 48'd300, 48'd64, P_RLC, 1'b1, 2'd1, n, to);
    total++;
    if (to || we_cnt != 1 || got_rec !== exp_rec(48'd300) || got_idx !== 2'd1) begin
      bad++; $display("FAIL rstmid_fresh: got we=%0d rec=%h want 1 %h", we_cnt, got_rec, exp_rec(48'd300));
    end
  endtask

  task automatic test_start_held();
    int n;
    gnt_pct = 100; dmin = 1; dmax = 1;
    load_rec300();
    @(posedge iw_clk); clr_mon();
    @(negedge iw_clk);
    iw_ea = 48'd300; iw_src_base = 48'd300; iw_src_len = 48'd64; iw_src_perms = P_RLC;
    iw_src_tag = 1'b1; iw_dst = 2'd0; iw_start = 1'b1; n = cyc;
    for (int k = 0; k < 200 && done_cnt < 2; k++) @(posedge iw_clk);
    @(negedge iw_clk); iw_start = 1'b0;
    repeat (20) @(posedge iw_clk);
    total++;
    if (done_cyc_q.size() != 2 || done_cyc_q[0] != n + 13 || done_cyc_q[1] != n + 27) begin
      bad++; $display("FAIL held_dones: got %0d dones at +%0d +%0d want 2 at +13 +27", done_cyc_q.size(),
                      done_cyc_q.size() > 0 ? done_cyc_q[0] - n : -1, done_cyc_q.size() > 1 ? done_cyc_q[1] - n : -1);
    end
    total++;
    if (busy_cnt != 26 || iss_q.size() != 20 || we_cnt != 2 || got_rec !== exp_rec(48'd300)) begin
      bad++; $display("FAIL held_ctl: got busy=%0d reqs=%0d we=%0d want 26 20 2", busy_cnt, iss_q.size(), we_cnt);
    end
  endtask

  initial begin
    iw_rst = 1'b1;
    mem_if.iw_mem_gnt = 1'b0; mem_if.iw_mem_rvalid = 1'b0; mem_if.iw_mem_rdata = '0;
    test_reset();
    test_basic();
    test_faults();
    test_bounds();
    test_random_timing();
    test_random();
    test_reset_mid();
    test_start_held();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
